// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, grant encoding
// and the round-robin priority pointer values.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_DBG  = 2'b10
  } grant_t;

  localparam logic PTR_CPU = 1'b0;
  localparam logic PTR_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester always wins and
// a tie goes to whichever port holds the priority pointer.
import mem_arb_pkg::*;

module rr_pick2 (
  input  logic [1:0] req,  // [0] cpu, [1] dbg
  input  logic       ptr,
  output grant_t     win
);

  always_comb begin
    win = GNT_NONE;
    case (req)
      2'b01:   win = GNT_CPU;
      2'b10:   win = GNT_DBG;
      2'b11:   win = (ptr == PTR_DBG) ? GNT_DBG : GNT_CPU;
      default: win = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory between the CPU and a debug/loader
// port; each access is latched at grant and held for MEM_LAT cycles.
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  generate
    if (MEM_LAT < 1) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be at least 1");
    end
  endgenerate

  state_t              state, state_nx;
  grant_t              gnt, win;
  logic                ptr;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  rr_pick2 u_pick (
    .req ({dbg_req, cpu_req}),
    .ptr (ptr),
    .win (win)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win != GNT_NONE) state_nx = BUSY;
      BUSY:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= GNT_NONE;
      ptr       <= PTR_CPU;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (win != GNT_NONE) begin
            gnt <= win;
            cnt <= CNT_LOAD;
            if (win == GNT_CPU) begin
              lat_we    <= cpu_we;
              lat_addr  <= cpu_addr;
              lat_wdata <= cpu_wdata;
            end else begin
              lat_we    <= dbg_we;
              lat_addr  <= dbg_addr;
              lat_wdata <= dbg_wdata;
            end
          end
        end
        BUSY: begin
          // Read data is only valid in the last BUSY cycle.
          if (cnt == '0) begin
            if (!lat_we) begin
              if (gnt == GNT_CPU) cpu_rdata <= mem_rdata;
              else                dbg_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          ptr <= (gnt == GNT_CPU) ? PTR_DBG : PTR_CPU;
          gnt <= GNT_NONE;
        end
        default: gnt <= GNT_NONE;
      endcase
    end
  end

  assign mem_en    = (state == BUSY);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_ready = (state == RESP) && (gnt == GNT_CPU);
  assign dbg_ready = (state == RESP) && (gnt == GNT_DBG);
  assign grant     = gnt;

endmodule
